// File: rtl/complex_arith_unit.sv
// Single-cycle complex add/sub/multiply with per-component saturation.
// Fixed-point multiply rescales by FRAC bits (floor) before saturating to W bits.
module complex_arith_unit #(
   parameter int W    = 16,
   parameter int FRAC = 15
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [1:0]   op,
   input  logic [W-1:0] a_re,
   input  logic [W-1:0] a_im,
   input  logic [W-1:0] b_re,
   input  logic [W-1:0] b_im,
   output logic         out_valid,
   output logic [W-1:0] out_re,
   output logic [W-1:0] out_im,
   output logic         ovf
);

   localparam int PW = 2*W + 1;
   localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_MUL  = 2'b10,
      OP_RSVD = 2'b11
   } op_t;

   // Result packing for both helpers: bit W is the saturation flag, bits W-1:0 the value.
   function automatic logic [W:0] sat_short(input logic [W:0] v);
      if (v[W] != v[W-1])
         sat_short = {1'b1, (v[W] ? MIN_VAL : MAX_VAL)};
      else
         sat_short = {1'b0, v[W-1:0]};
   endfunction

   function automatic logic [W:0] sat_long(input logic [PW-1:0] v);
      if (v[PW-1:W-1] != {(PW-W+1){v[PW-1]}})
         sat_long = {1'b1, (v[PW-1] ? MIN_VAL : MAX_VAL)};
      else
         sat_long = {1'b0, v[W-1:0]};
   endfunction

   logic [W:0] add_re, add_im, sub_re, sub_im;

   assign add_re = {a_re[W-1], a_re} + {b_re[W-1], b_re};
   assign add_im = {a_im[W-1], a_im} + {b_im[W-1], b_im};
   assign sub_re = {a_re[W-1], a_re} - {b_re[W-1], b_re};
   assign sub_im = {a_im[W-1], a_im} - {b_im[W-1], b_im};

   // Operands widened to 2W so every product is exact before the 2W+1 bit sums.
   logic signed [2*W-1:0] a_re_x, a_im_x, b_re_x, b_im_x;
   logic signed [2*W-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [PW-1:0]  mul_re, mul_im, mul_re_sh, mul_im_sh;

   assign a_re_x = {{W{a_re[W-1]}}, a_re};
   assign a_im_x = {{W{a_im[W-1]}}, a_im};
   assign b_re_x = {{W{b_re[W-1]}}, b_re};
   assign b_im_x = {{W{b_im[W-1]}}, b_im};

   assign p_rr = a_re_x * b_re_x;
   assign p_ii = a_im_x * b_im_x;
   assign p_ri = a_re_x * b_im_x;
   assign p_ir = a_im_x * b_re_x;

   assign mul_re = {p_rr[2*W-1], p_rr} - {p_ii[2*W-1], p_ii};
   assign mul_im = {p_ri[2*W-1], p_ri} + {p_ir[2*W-1], p_ir};

   assign mul_re_sh = mul_re >>> FRAC;
   assign mul_im_sh = mul_im >>> FRAC;

   logic [W:0] res_re, res_im;

   always_comb begin
      res_re = '0;
      res_im = '0;
      case (op_t'(op))
         OP_ADD: begin
            res_re = sat_short(add_re);
            res_im = sat_short(add_im);
         end
         OP_SUB: begin
            res_re = sat_short(sub_re);
            res_im = sat_short(sub_im);
         end
         OP_MUL: begin
            res_re = sat_long(mul_re_sh);
            res_im = sat_long(mul_im_sh);
         end
         default: begin
            res_re = '0;
            res_im = '0;
         end
      endcase
   end

   // Data outputs only update on valid cycles so the last result stays visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         ovf       <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_re <= res_re[W-1:0];
            out_im <= res_im[W-1:0];
            ovf    <= res_re[W] | res_im[W];
         end
      end
   end

endmodule

// File: tb/tb_complex_arith_unit.sv
// Randomized self-checking bench for complex_arith_unit (W=16, FRAC=15)
// against an integer-arithmetic reference model.
module tb_complex_arith_unit;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [1:0]  op;
   logic [15:0] a_re, a_im, b_re, b_im;
   logic        out_valid;
   logic [15:0] out_re, out_im;
   logic        ovf;

   int checks;
   int failures;

   // Expected registered outputs held by the reference model
   longint exp_re, exp_im;
   bit     exp_valid, exp_ovf;

   complex_arith_unit #(.W(16), .FRAC(15)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .op        (op),
      .a_re      (a_re),
      .a_im      (a_im),
      .b_re      (b_re),
      .b_im      (b_im),
      .out_valid (out_valid),
      .out_re    (out_re),
      .out_im    (out_im),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input longint got, input longint want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, want);
      end
   endtask

   function automatic longint clamp16(input longint v, inout bit flag);
      if (v > 32767) begin
         flag = 1'b1;
         return 32767;
      end
      if (v < -32768) begin
         flag = 1'b1;
         return -32768;
      end
      return v;
   endfunction

   // Reference: plain integer math on the component values, floor division for rescale
   task automatic updateModel(input bit r, input bit v, input int o,
                              input longint ar, input longint ai,
                              input longint br, input longint bi);
      bit     f;
      longint re, im;
      if (r) begin
         exp_valid = 1'b0;
         exp_re    = 0;
         exp_im    = 0;
         exp_ovf   = 1'b0;
         return;
      end
      exp_valid = v;
      if (!v) return;
      f = 1'b0;
      case (o)
         0: begin re = ar + br; im = ai + bi; end
         1: begin re = ar - br; im = ai - bi; end
         2: begin
            re = (ar*br - ai*bi) >>> 15;
            im = (ar*bi + ai*br) >>> 15;
         end
         default: begin re = 0; im = 0; end
      endcase
      exp_re  = clamp16(re, f);
      exp_im  = clamp16(im, f);
      exp_ovf = f;
   endtask

   task automatic applyStimulus(input bit r, input bit v, input int o,
                                input int ar, input int ai,
                                input int br, input int bi, input string tag);
      rst      = r;
      in_valid = v;
      op       = o[1:0];
      a_re     = ar[15:0];
      a_im     = ai[15:0];
      b_re     = br[15:0];
      b_im     = bi[15:0];
      @(posedge clk);
      #1;
      updateModel(r, v, o, ar, ai, br, bi);
      checkOutput({tag, ".valid"}, longint'(out_valid), longint'(exp_valid));
      checkOutput({tag, ".re"},    longint'($signed(out_re)), exp_re);
      checkOutput({tag, ".im"},    longint'($signed(out_im)), exp_im);
      checkOutput({tag, ".ovf"},   longint'(ovf), longint'(exp_ovf));
   endtask

   function automatic int pickOperand();
      case ($urandom_range(0, 7))
         0: return -32768;
         1: return 32767;
         2: return 0;
         3: return -1;
         default: return int'($urandom_range(0, 65535)) - 32768;
      endcase
   endfunction

   initial begin
      checks   = 0;
      failures = 0;
      rst = 1'b1; in_valid = 1'b0; op = 2'b00;
      a_re = '0; a_im = '0; b_re = '0; b_im = '0;

      // Reset overrides a valid operation presented alongside it
      applyStimulus(1, 1, 0, 1234, 567, 89, 10, "reset0");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, "reset1");

      applyStimulus(0, 1, 0, 100, -200, 50, 25, "add");
      applyStimulus(0, 1, 1, -32768, 32767, 1, -1, "sub_sat");
      applyStimulus(0, 1, 2, 16384, 0, 0, 16384, "mul");
      applyStimulus(0, 1, 2, -1, 0, 1, 0, "mul_floor");
      applyStimulus(0, 1, 2, -32768, 0, -32768, 0, "mul_corner");
      applyStimulus(0, 1, 3, 500, 600, 700, 800, "reserved");

      // Back-to-back different ops, then a hold cycle
      applyStimulus(0, 1, 0, 32767, -32768, 1, -1, "b2b_add");
      applyStimulus(0, 1, 2, 23170, 23170, 23170, -23170, "b2b_mul");
      applyStimulus(0, 1, 1, 10, 20, 30, 40, "b2b_sub");
      applyStimulus(0, 0, 0, 1, 1, 1, 1, "hold0");
      applyStimulus(0, 0, 2, 9, 9, 9, 9, "hold1");

      // Reset mid-stream then resume
      applyStimulus(0, 1, 0, 7, 8, 9, 10, "pre_rst");
      applyStimulus(1, 1, 2, 16384, 16384, 16384, 16384, "mid_rst");
      applyStimulus(0, 1, 0, -5, 5, -6, 6, "post_rst");

      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 39) == 0),
                       ($urandom_range(0, 3) != 0),
                       int'($urandom_range(0, 3)),
                       pickOperand(), pickOperand(), pickOperand(), pickOperand(),
                       "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
